button_debouncer: RTL and testbench
===================================

# button_debouncer

Debounces up to NUM_BTN raw, asynchronous push-button inputs and converts them into clean, single-clock event pulses.
- Events: press, release and hold-to-repeat.
- Intended as the input-side companion of the LED counter and display blocks on the iCE40 board. Its pulses drive counters and menus directly; the consumer adds no extra qualification.
- Sampling uses an internal prescaler tick, so bounce filtering is in real time rather than in clock cycles.

## Interface
Parameters:
- NUM_BTN, 4, number of independent button channels (1..8)
- SAMPLE_TOP, 99999, prescaler terminal count; sample tick every SAMPLE_TOP+1 clocks (1 ms at 100 MHz)
- STABLE_SAMPLES, 10, consecutive disagreeing samples required to accept a new level (>=1)
- REPEAT_DELAY, 500, sample ticks from accepted press to first repeat pulse (>=1)
- REPEAT_RATE, 100, sample ticks between subsequent repeat pulses (>=1)

Ports:
- clk  in  1  system clock (100 MHz); one clock domain
- rst  in  1  reset; asynchronous, active-high
- btn_in  in  NUM_BTN  raw button levels, active-high, asynchronous to clk
- btn_state  out  NUM_BTN  debounced level per button
- press  out  NUM_BTN  one-clk pulse on accepted 0->1
- release  out  NUM_BTN  one-clk pulse on accepted 1->0
- repeat  out  NUM_BTN  one-clk pulse per auto-repeat while held
- tick  out  1  one-clk sample strobe (debug/test)

## Operation
- Synchronizer: btn_in passes through a 2-flop synchronizer per bit, giving sync[i]. All later logic uses sync only.
- Prescaler: ceil(log2(SAMPLE_TOP+1))-bit counter, 0..SAMPLE_TOP.
  - tick asserts in the cycle the count equals SAMPLE_TOP; the count then wraps to 0.
- Debounce, per button, evaluated only on tick cycles:
  - If sync[i] == btn_state[i], clear cnt[i].
  - Else, if cnt[i] == STABLE_SAMPLES-1: toggle btn_state[i], clear cnt[i], and register press[i] (new level 1) or release[i] (new level 0).
  - Else increment cnt[i].
  - A single agreeing sample restarts the count. A glitch shorter than STABLE_SAMPLES ticks never changes btn_state.
- Repeat FSM per button, with states IDLE, DELAY, REPEAT and counter rcnt[i]. All transitions occur on tick cycles only.
  - IDLE: on accepted press -> DELAY, rcnt=0.
  - DELAY: rcnt == REPEAT_DELAY-1 -> pulse repeat, rcnt=0, go to REPEAT; otherwise rcnt++.
  - REPEAT: rcnt == REPEAT_RATE-1 -> pulse repeat, rcnt=0; otherwise rcnt++.
  - Accepted release from DELAY or REPEAT -> IDLE, rcnt=0.
- Simultaneous events:
  - Release takes priority over a repeat due on the same tick; that repeat is suppressed.
  - The press tick never emits repeat.
  - Channels are fully independent; any combination of pulses across channels may coincide.
- Counter widths: sized to hold STABLE_SAMPLES-1 and max(REPEAT_DELAY, REPEAT_RATE)-1. The counters never wrap.

## Timing
- Reset values: btn_state=0, press=0, release=0, repeat=0, tick=0; prescaler=0; all cnt, rcnt = 0; FSMs in IDLE; synchronizer flops = 0.
- Reset asserted mid-operation:
  - All of the above apply immediately, with no pulse emitted.
  - A button held through reset release produces a press after full debounce.
- Output registration: press, release, repeat and tick are registered; each is high for exactly one clk.
  - tick is high during the cycle the prescaler holds SAMPLE_TOP.
  - press, release and repeat assert in the clk after the deciding tick cycle. btn_state updates in that same clk.
- Latency from a clean btn_in edge to press:
  - 2 clks of synchronizer,
  - plus the wait to the next tick,
  - plus (STABLE_SAMPLES-1) × (SAMPLE_TOP+1) clks,
  - plus 1 clk.
- Repeat timing: first repeat occurs REPEAT_DELAY ticks after the press tick; subsequent repeats every REPEAT_RATE ticks.

## Test plan
All scenarios use SAMPLE_TOP=3, STABLE_SAMPLES=4, REPEAT_DELAY=5, REPEAT_RATE=2, NUM_BTN=4.
- Clean press: btn_in[0] 0->1 held -> press[0] is one clk wide, btn_state[0]=1, on the 4th tick after the sync edge; release[0] and repeat[0] stay 0.
- Bounce reject:
  - btn_in[1] toggles with 3-tick-high / 1-tick-low glitches -> no press[1], btn_state[1] stays 0.
  - Then held steady -> press[1] on the 4th consecutive high tick.
- Hold repeat: btn_in[2] held 20 ticks after press -> repeat[2] at press tick +5, +7, +9 … ticks, exactly one clk each, never coincident with press[2].
- Release priority:
  - Release btn_in[2] so the release is accepted on the tick a repeat is due -> release[2] pulses, no repeat[2].
  - FSM returns to IDLE; a later press restarts the 5-tick delay.
- Multi-channel: btn_in[0] and btn_in[3] pressed in the same clk -> press[0] and press[3] in the same clk; independent releases -> independent release pulses.
- Reset mid-hold: assert rst while btn_state=4'b0101 with repeats active -> all outputs 0 immediately. Release rst with btn_in held -> fresh press after 4 ticks, no stray release.

Source files
------------

// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer with press/release/auto-repeat pulses.
// The release and repeat ports carry a _pulse suffix because both bare words are SystemVerilog keywords.
module button_debouncer #(
  parameter int NUM_BTN        = 4,
  parameter int SAMPLE_TOP     = 99999,
  parameter int STABLE_SAMPLES = 10,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_state,
  output logic [NUM_BTN-1:0] press,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic [NUM_BTN-1:0] repeat_pulse,
  output logic               tick
);

  localparam int PW   = (SAMPLE_TOP > 0) ? $clog2(SAMPLE_TOP + 1) : 1;
  localparam int CW   = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY
                                                     : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RPT
  } rstate_t;

  logic [NUM_BTN-1:0] meta, sync;
  logic [PW-1:0]      pcnt, pcnt_d;
  logic [CW-1:0]      cnt_q  [NUM_BTN];
  logic [CW-1:0]      cnt_d  [NUM_BTN];
  logic [RW-1:0]      rcnt_q [NUM_BTN];
  logic [RW-1:0]      rcnt_d [NUM_BTN];
  rstate_t            rs_q   [NUM_BTN];
  rstate_t            rs_d   [NUM_BTN];
  logic [NUM_BTN-1:0] state_d, press_d, rel_d, rep_d;

  // Two-flop synchronizer for the raw asynchronous button levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= btn_in;
      sync <= meta;
    end
  end

  // Prescaler next count, wrapping after the terminal value
  always_comb begin
    pcnt_d = pcnt + PW'(1);
    if (pcnt == PW'(SAMPLE_TOP))
      pcnt_d = '0;
  end

  // Prescaler register; tick is registered to coincide with the terminal count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      pcnt <= pcnt_d;
      tick <= (pcnt_d == PW'(SAMPLE_TOP));
    end
  end

  // Debounce decision: count consecutive disagreeing samples on each tick
  always_comb begin
    state_d = btn_state;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync[i] == btn_state[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CW'(STABLE_SAMPLES - 1)) begin
          cnt_d[i]   = '0;
          state_d[i] = sync[i];
          press_d[i] = sync[i];
          rel_d[i]   = ~sync[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Repeat FSM next state; a release on the same tick masks a due repeat
  always_comb begin
    rep_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      rs_d[i]   = rs_q[i];
      rcnt_d[i] = rcnt_q[i];
      if (tick) begin
        case (rs_q[i])
          IDLE: begin
            if (press_d[i]) begin
              rs_d[i]   = DELAY;
              rcnt_d[i] = '0;
            end
          end
          DELAY: begin
            if (rel_d[i]) begin
              rs_d[i]   = IDLE;
              rcnt_d[i] = '0;
            end else if (rcnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
              rs_d[i]   = RPT;
              rcnt_d[i] = '0;
              rep_d[i]  = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          RPT: begin
            if (rel_d[i]) begin
              rs_d[i]   = IDLE;
              rcnt_d[i] = '0;
            end else if (rcnt_q[i] == RW'(REPEAT_RATE - 1)) begin
              rcnt_d[i] = '0;
              rep_d[i]  = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: begin
            rs_d[i]   = IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // Per-channel state and registered one-clock event pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_state     <= '0;
      press         <= '0;
      release_pulse <= '0;
      repeat_pulse  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i]  <= '0;
        rcnt_q[i] <= '0;
        rs_q[i]   <= IDLE;
      end
    end else begin
      btn_state     <= state_d;
      press         <= press_d;
      release_pulse <= rel_d;
      repeat_pulse  <= rep_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i]  <= cnt_d[i];
        rcnt_q[i] <= rcnt_d[i];
        rs_q[i]   <= rs_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer with small prescaler settings.
// Expected pulses are queued by cycle number; a monitor pops them as they appear.
module tb_button_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_state, press, rel, rep;
  logic       tick;

  int cyc;
  int n_tests;
  int n_fail;

  typedef struct {
    int       c;
    logic [3:0] p;
    logic [3:0] r;
    logic [3:0] q;
    logic [3:0] s;
  } ev_t;

  ev_t sb[$];

  button_debouncer #(
    .NUM_BTN(4),
    .SAMPLE_TOP(3),
    .STABLE_SAMPLES(4),
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .btn_state(btn_state),
    .press(press),
    .release_pulse(rel),
    .repeat_pulse(rep),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic void exp_ev(int c, logic [3:0] p, logic [3:0] r,
                                 logic [3:0] q, logic [3:0] s);
    ev_t e;
    e.c = c; e.p = p; e.r = r; e.q = q; e.s = s;
    sb.push_back(e);
  endfunction

  task automatic chk(string nm, logic [3:0] act, logic [3:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, expv);
    end
  endtask

  task automatic at(int c, logic [3:0] v);
    while (cyc != c) @(negedge clk);
    btn_in = v;
  endtask

  // Monitor: tick cadence every cycle, pulses checked against the queue
  initial begin
    ev_t  e;
    logic et;
    forever begin
      @(negedge clk);
      if (!rst) begin
        et = (cyc % 4 == 3);
        n_tests++;
        if (tick !== et) begin
          n_fail++;
          $display("FAIL tick cyc=%0d: got %b expected %b", cyc, tick, et);
        end
        if ((press | rel | rep) != 4'b0) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse cyc=%0d p=%b r=%b q=%b s=%b",
                     cyc, press, rel, rep, btn_state);
          end else begin
            e = sb.pop_front();
            if (e.c != cyc || e.p !== press || e.r !== rel ||
                e.q !== rep || e.s !== btn_state) begin
              n_fail++;
              $display("FAIL event: got cyc=%0d p=%b r=%b q=%b s=%b expected cyc=%0d p=%b r=%b q=%b s=%b",
                       cyc, press, rel, rep, btn_state,
                       e.c, e.p, e.r, e.q, e.s);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    btn_in  = 4'b0;

    // clean press ch0, released before the first repeat
    exp_ev(20, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    exp_ev(36, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    // bounce on ch1 rejected, then steady press and release
    exp_ev(96, 4'b0010, 4'b0000, 4'b0000, 4'b0010);
    exp_ev(112, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    // hold ch2: repeats at press tick +5, +7, ...
    exp_ev(136, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    for (int k = 0; k < 8; k++)
      exp_ev(156 + 8 * k, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    // release lands on a due repeat tick: repeat suppressed
    exp_ev(220, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    // re-press restarts the full delay
    exp_ev(248, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    exp_ev(268, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    exp_ev(272, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    // ch0 and ch3 together, then independent releases
    exp_ev(304, 4'b1001, 4'b0000, 4'b0000, 4'b1001);
    exp_ev(320, 4'b0000, 4'b0001, 4'b0000, 4'b1000);
    exp_ev(324, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
    exp_ev(332, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    // ch0 and ch2 held with repeats before reset
    exp_ev(360, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    exp_ev(380, 4'b0000, 4'b0000, 4'b0101, 4'b0101);
    exp_ev(388, 4'b0000, 4'b0000, 4'b0101, 4'b0101);

    repeat (3) @(negedge clk);
    chk("reset_state", btn_state, 4'b0);
    chk("reset_press", press, 4'b0);
    chk("reset_release", rel, 4'b0);
    chk("reset_repeat", rep, 4'b0);
    chk("reset_tick", {3'b0, tick}, 4'b0);
    rst = 1'b0;

    at(4,   4'b0001);
    at(20,  4'b0000);
    at(48,  4'b0010);
    at(60,  4'b0000);
    at(64,  4'b0010);
    at(76,  4'b0000);
    at(80,  4'b0010);
    at(96,  4'b0000);
    at(120, 4'b0100);
    at(204, 4'b0000);
    at(232, 4'b0100);
    at(256, 4'b0000);
    at(288, 4'b1001);
    at(304, 4'b1000);
    at(316, 4'b0000);
    at(344, 4'b0101);

    // reset while a repeat pulse is on the outputs
    while (cyc != 388) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", btn_state, 4'b0);
    chk("midrst_press", press, 4'b0);
    chk("midrst_release", rel, 4'b0);
    chk("midrst_repeat", rep, 4'b0);
    chk("midrst_tick", {3'b0, tick}, 4'b0);
    chk("midrst_queue", 4'(sb.size()), 4'b0);

    // after reset: fresh press, repeats, then release
    exp_ev(16, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    for (int k = 0; k < 5; k++)
      exp_ev(36 + 8 * k, 4'b0000, 4'b0000, 4'b0101, 4'b0101);
    exp_ev(72, 4'b0000, 4'b0101, 4'b0000, 4'b0000);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    at(56, 4'b0000);
    while (cyc != 100) @(negedge clk);
    chk("final_queue_empty", 4'(sb.size()), 4'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
